// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
// - md_op encodings for MULT/MULTU/DIV/DIVU/MTHI/MTLO (6 and 7 mean "no md op").
// - Default busy-cycle counts for multiply and divide.
// - Sequencer state type.
package md_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    localparam logic [2:0] MD_NONE  = 3'd7;

    localparam int MD_MULT_CYC = 5;
    localparam int MD_DIV_CYC  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // True for the ops that launch a multi-cycle sequence.
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage; owns architectural HI/LO.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             E-stage MULT/MULTU/DIV/DIVU (one-cycle pulse)
//   md_op[2:0]        operation select (md_unit_pkg encodings)
//   flush             E stage being flushed; cancels start/MTHI/MTLO this cycle
//   a, b[31:0]        forwarded rs / rt operands
//   D_is_md           D-stage instruction touches the md unit
//   busy              operation in flight (registered)
//   md_stall_req      D_is_md & (start | busy), combinational
//   hi, lo[31:0]      architectural HI/LO
// The result is computed combinationally in the start cycle and parked in
// temp registers; the busy countdown only models latency before commit.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYC,
    parameter int DIV_CYCLES  = MD_DIV_CYC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        D_is_md,
    output logic        busy,
    output logic        md_stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
    logic        wr_q, wr_d;   // commit enable; cleared for divide by zero

    logic [63:0]        prod_s, prod_u;
    logic [31:0]        b_nz, quot_u, rem_u;
    logic signed [31:0] a_s, b_s, quot_s, rem_s;

    // Arithmetic datapath. b_nz keeps the divider defined when b==0; that
    // result is never committed.
    always_comb begin
        b_nz   = (b == 32'd0) ? 32'd1 : b;
        a_s    = signed'(a);
        b_s    = signed'(b_nz);
        // Low 64 bits of the sign-extended product equal the signed product.
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};
        quot_s = a_s / b_s;
        rem_s  = a_s % b_s;
        quot_u = a / b_nz;
        rem_u  = a % b_nz;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        wr_d     = wr_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush && md_is_arith(md_op)) begin
                    state_d = ST_BUSY;
                    wr_d    = 1'b1;
                    case (md_op)
                        MD_MULT: begin
                            {hi_tmp_d, lo_tmp_d} = prod_s;
                            cnt_d = 4'(MULT_CYCLES);
                        end
                        MD_MULTU: begin
                            {hi_tmp_d, lo_tmp_d} = prod_u;
                            cnt_d = 4'(MULT_CYCLES);
                        end
                        MD_DIV: begin
                            hi_tmp_d = 32'(rem_s);
                            lo_tmp_d = 32'(quot_s);
                            wr_d     = (b != 32'd0);
                            cnt_d    = 4'(DIV_CYCLES);
                        end
                        default: begin
                            hi_tmp_d = rem_u;
                            lo_tmp_d = quot_u;
                            wr_d     = (b != 32'd0);
                            cnt_d    = 4'(DIV_CYCLES);
                        end
                    endcase
                end else if (!flush && !start) begin
                    if (md_op == MD_MTHI) hi_d = a;
                    if (md_op == MD_MTLO) lo_d = a;
                end
            end
            default: begin
                // Flush is ignored here: the owning instruction already left E.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    if (wr_q) begin
                        hi_d = hi_tmp_q;
                        lo_d = lo_tmp_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hi_tmp_q <= 32'd0;
            lo_tmp_q <= 32'd0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            wr_q     <= wr_d;
        end
    end

    assign busy         = (state_q == ST_BUSY);
    assign md_stall_req = D_is_md & (start | busy);
    assign hi           = hi_q;
    assign lo           = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic        flush;
    logic [31:0] a, b;
    logic        D_is_md;
    logic        busy, md_stall_req;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .flush(flush),
        .a(a), .b(b), .D_is_md(D_is_md), .busy(busy),
        .md_stall_req(md_stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // The hazard unit must never present start while busy.
    always @(posedge clk) begin
        if (!reset) assert (!(start && busy)) else $error("start while busy");
    end

    // Reference model: plain arithmetic on 64-bit integers.
    function automatic void ref_calc(input logic [2:0] op, input logic [31:0] av, bv,
                                     input logic [31:0] old_hi, old_lo,
                                     output logic [31:0] eh, el);
        longint sa, sb, ma, mb, q, r, p;
        longint unsigned pu;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        eh = old_hi;
        el = old_lo;
        case (op)
            MD_MULT: begin
                p  = sa * sb;
                eh = p[63:32]; el = p[31:0];
            end
            MD_MULTU: begin
                pu = longint'(av) * longint'(bv);
                eh = pu[63:32]; el = pu[31:0];
            end
            MD_DIV: if (bv != 0) begin
                ma = (sa < 0) ? -sa : sa;
                mb = (sb < 0) ? -sb : sb;
                q  = ma / mb;
                if ((sa < 0) != (sb < 0)) q = -q;
                r  = sa - q * sb;
                eh = r[31:0]; el = q[31:0];
            end
            default: if (bv != 0) begin
                el = av / bv;
                eh = av % bv;
            end
        endcase
    endfunction

    // Launch one arithmetic op from an idle cycle and follow it to commit.
    task automatic do_op(input logic [2:0] op, input logic [31:0] av, bv,
                         input int n, input logic [31:0] eh, el, input string nm);
        logic [31:0] old_hi, old_lo;
        int cnt;
        old_hi = hi;
        old_lo = lo;
        start = 1'b1; md_op = op; a = av; b = bv;
        #1;
        checks++;
        if (md_stall_req !== D_is_md) begin
            failures++;
            $display("FAIL %s stall_start got=%b exp=%b", nm, md_stall_req, D_is_md);
        end
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE; a = $urandom; b = $urandom;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            checks++;
            if (md_stall_req !== D_is_md || hi !== old_hi || lo !== old_lo) begin
                failures++;
                $display("FAIL %s busy_cyc%0d stall=%b hi=%h lo=%h exp stall=%b hi=%h lo=%h",
                         nm, cnt, md_stall_req, hi, lo, D_is_md, old_hi, old_lo);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (cnt != n) begin
            failures++;
            $display("FAIL %s busy_len got=%0d exp=%0d", nm, cnt, n);
        end
        checks++;
        if (hi !== eh || lo !== el) begin
            failures++;
            $display("FAIL %s result hi=%h lo=%h exp hi=%h lo=%h", nm, hi, lo, eh, el);
        end
        checks++;
        if (md_stall_req !== 1'b0) begin
            failures++;
            $display("FAIL %s stall_after got=%b exp=0", nm, md_stall_req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || md_stall_req !== 1'b0) begin
            failures++;
            $display("FAIL reset busy=%b hi=%h lo=%h stall=%b exp 0/0/0/0", busy, hi, lo, md_stall_req);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_release busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
        end
    endtask

    task automatic test_mult();
        D_is_md = 1'b0;
        do_op(MD_MULT,  32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult");
        do_op(MD_MULTU, 32'hFFFFFFFD, 32'd5, 5, 32'h00000004, 32'hFFFFFFF1, "multu");
    endtask

    task automatic test_div();
        do_op(MD_DIV,  32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
        do_op(MD_DIVU, 32'd7,        32'd2, 10, 32'd1,        32'd3,        "divu");
    endtask

    task automatic test_mt_div0();
        md_op = MD_MTHI; a = 32'h11;
        @(posedge clk); #1;
        checks++;
        if (hi !== 32'h11 || lo !== 32'd3) begin
            failures++;
            $display("FAIL mthi hi=%h lo=%h exp hi=00000011 lo=00000003", hi, lo);
        end
        md_op = MD_MTLO; a = 32'h22;
        @(posedge clk); #1;
        checks++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            failures++;
            $display("FAIL mtlo hi=%h lo=%h exp hi=00000011 lo=00000022", hi, lo);
        end
        md_op = MD_NONE;
        do_op(MD_DIV, 32'h1234, 32'd0, 10, 32'h11, 32'h22, "div0");
    endtask

    task automatic test_flush_reset();
        start = 1'b1; flush = 1'b1; md_op = MD_MULT; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_MTHI; a = 32'hDEAD;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
            failures++;
            $display("FAIL flush busy=%b hi=%h lo=%h exp 0/00000011/00000022", busy, hi, lo);
        end
        flush = 1'b0; md_op = MD_NONE;
        start = 1'b1; md_op = MD_DIV; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE;
        // Flush while busy must not disturb the in-flight op.
        flush = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        flush = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL async_reset busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        D_is_md = 1'b1;
        do_op(MD_MULT, 32'd6, 32'hFFFFFFFF, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, "stall_mult");
        D_is_md = 1'b0;
    endtask

    task automatic test_flush_busy();
        logic [31:0] eh, el;
        ref_calc(MD_DIVU, 32'd1000, 32'd33, hi, lo, eh, el);
        flush = 1'b0;
        start = 1'b1; md_op = MD_DIVU; a = 32'd1000; b = 32'd33;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE; flush = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== eh || lo !== el) begin
            failures++;
            $display("FAIL flush_busy busy=%b hi=%h lo=%h exp 0/%h/%h", busy, hi, lo, eh, el);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] av, bv, eh, el;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 5));
            av = $urandom;
            bv = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if ($urandom_range(0, 1) != 0) bv = -bv;
            if (av == 32'h80000000 && bv == 32'hFFFFFFFF) bv = 32'd3;
            D_is_md = 1'($urandom_range(0, 1));
            if (op == MD_MTHI || op == MD_MTLO) begin
                eh = (op == MD_MTHI) ? av : hi;
                el = (op == MD_MTLO) ? av : lo;
                md_op = op; a = av;
                @(posedge clk); #1;
                md_op = MD_NONE;
                checks++;
                if (hi !== eh || lo !== el || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL rand%0d_mt hi=%h lo=%h busy=%b exp %h/%h/0", i, hi, lo, busy, eh, el);
                end
            end else begin
                ref_calc(op, av, bv, hi, lo, eh, el);
                do_op(op, av, bv, (op == MD_MULT || op == MD_MULTU) ? 5 : 10, eh, el, "rand");
            end
        end
        D_is_md = 1'b0;
    endtask

    initial begin
        start = 1'b0; md_op = MD_NONE; flush = 1'b0; a = '0; b = '0; D_is_md = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_mt_div0();
        test_flush_reset();
        test_stall();
        test_flush_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
